// File: rtl/simple_uart_pkg.sv
// Shared types and line-level constants for the simple UART blocks.
package simple_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

    localparam logic UART_START_BIT  = 1'b0;
    localparam logic UART_STOP_BIT   = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_W     = 8;

endpackage

// File: rtl/simple_uart_baud_tick.sv
// Bit-period counter: bit_tick marks the last clk of each line bit.
module simple_uart_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] baud_cnt;

    // With CLKS_PER_BIT == 1 the counter stays at 0 and bit_tick is constantly high.
    assign bit_tick = (baud_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if (clear || bit_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/simple_uart_tx.sv
// UART transmitter: start bit, DATA_W bits MSB first, stop bit; one-entry holding register.
module simple_uart_tx
    import simple_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    input  logic              d_valid,
    output logic              d_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    uart_tx_state_t    state;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] shift;
    logic              hold_full;
    logic [BW-1:0]     bit_cnt;
    logic              bit_tick;
    logic              accept;
    logic              load;
    logic              shift_step;

    assign d_ready    = ~hold_full;
    assign accept     = d_valid & ~hold_full;
    // Load only happens with hold_full set and accept only with it clear, so they never collide.
    assign load       = hold_full & ((state == IDLE) | ((state == STOP) & bit_tick));
    assign shift_step = (state == DATA) & bit_tick & (bit_cnt != LAST_BIT);
    assign frame_done = (state == STOP) & bit_tick;

    simple_uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == IDLE),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            hold <= d;
        end
        if (load) begin
            shift <= hold;
        end else if (shift_step) begin
            shift <= shift << 1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tx        <= UART_IDLE_LEVEL;
            busy      <= 1'b0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hold_full) begin
                        state <= START;
                        tx    <= UART_START_BIT;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        tx      <= shift[DATA_W-1];
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            tx    <= UART_STOP_BIT;
                        end else begin
                            // shift is updated this same edge, so the next MSB is one below the top.
                            tx      <= shift[DATA_W-2];
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (hold_full) begin
                            state <= START;
                            tx    <= UART_START_BIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= UART_IDLE_LEVEL;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simple_uart_tx.sv
// Self-checking bench for simple_uart_tx: bit-exact frames, streaming loopback, backpressure, reset.
module tb_simple_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] d1, d4;
    logic       dv1, dv4;
    logic       rdy1, tx1, busy1, fd1;
    logic       rdy4, tx4, busy4, fd4;

    always #5 clk = ~clk;

    simple_uart_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
        .clk(clk), .reset(rst_n), .d(d1), .d_valid(dv1), .d_ready(rdy1),
        .tx(tx1), .busy(busy1), .frame_done(fd1)
    );

    simple_uart_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
        .clk(clk), .reset(rst_n), .d(d4), .d_valid(dv4), .d_ready(rdy4),
        .tx(tx4), .busy(busy4), .frame_done(fd4)
    );

    int checks = 0;
    int fails  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int frame_err = 0;

    // Reference deserialiser on the one-clk-per-bit line, sampled mid-cycle.
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_active = 1'b0;
            rx_cnt    = 0;
        end else if (!rx_active) begin
            if (tx1 === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else if (rx_cnt < 8) begin
            rx_sh  = {rx_sh[6:0], tx1};
            rx_cnt = rx_cnt + 1;
        end else begin
            got_q.push_back(rx_sh);
            if (tx1 !== 1'b1) frame_err = frame_err + 1;
            rx_active = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, output int waited);
        int n = 0;
        exp_q.push_back(b);
        d1  = b;
        dv1 = 1'b1;
        while (!rdy1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy1 !== 1'b1) begin
            fails++;
            $display("FAIL send_accept: d_ready=%b after %0d clks, required 1", rdy1, n);
        end
        @(posedge clk);
        @(negedge clk);
        waited = n;
    endtask

    task automatic wait_rx(input int n);
        int c = 0;
        while (got_q.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        dv1 = 1'b0; dv4 = 1'b0; d1 = 8'h00; d4 = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx1, busy1, fd1, rdy1} !== 4'b1001) begin
            fails++;
            $display("FAIL reset_dut1: tx,busy,frame_done,d_ready=%b required 1001", {tx1, busy1, fd1, rdy1});
        end
        checks++;
        if ({tx4, busy4, fd4, rdy4} !== 4'b1001) begin
            fails++;
            $display("FAIL reset_dut4: tx,busy,frame_done,d_ready=%b required 1001", {tx4, busy4, fd4, rdy4});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame;
        logic [9:0] pat;
        logic [2:0] expv;
        logic [7:0] got, expb;
        pat = {1'b0, 8'hA5, 1'b1};
        exp_q.push_back(8'hA5);
        d1 = 8'hA5; dv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv1 = 1'b0; d1 = 8'hxx;
        checks++;
        if ({rdy1, tx1} !== 2'b01) begin
            fails++;
            $display("FAIL a5_after_accept: d_ready,tx=%b required 01", {rdy1, tx1});
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            expv = {pat[9-j], 1'b1, (j == 9)};
            checks++;
            if ({tx1, busy1, fd1} !== expv) begin
                fails++;
                $display("FAIL a5_bit%0d: tx,busy,frame_done=%b required %b", j, {tx1, busy1, fd1}, expv);
            end
        end
        @(negedge clk);
        checks++;
        if ({tx1, busy1, fd1} !== 3'b100) begin
            fails++;
            $display("FAIL a5_idle_after: tx,busy,frame_done=%b required 100", {tx1, busy1, fd1});
        end
        wait_rx(1);
        got  = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (got !== expb) begin
            fails++;
            $display("FAIL a5_decoded: got %h required %h", got, expb);
        end
    endtask

    task automatic test_loopback_stream;
        int run = 0, fdc = 0, w;
        logic [7:0] got, expb;
        fork
            begin
                send_byte(8'h00, w);
                send_byte(8'hFF, w);
                send_byte(8'h5A, w);
                dv1 = 1'b0;
            end
            begin
                int n = 0;
                while (!busy1 && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                while (busy1 && run < 100) begin
                    if (fd1) fdc++;
                    run++;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (run !== 30) begin
            fails++;
            $display("FAIL stream_contiguous: busy run %0d clks required 30", run);
        end
        checks++;
        if (fdc !== 3) begin
            fails++;
            $display("FAIL stream_frame_done: %0d pulses required 3", fdc);
        end
        wait_rx(3);
        checks++;
        if (got_q.size() !== 3) begin
            fails++;
            $display("FAIL stream_count: %0d bytes required 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got  = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== expb) begin
                fails++;
                $display("FAIL stream_byte%0d: got %h required %h", i, got, expb);
            end
        end
        checks++;
        if (frame_err !== 0) begin
            fails++;
            $display("FAIL stream_stop_bits: %0d bad stop bits required 0", frame_err);
        end
    endtask

    task automatic test_backpressure;
        int w1, w2, w3;
        logic [7:0] got, expb;
        repeat (3) @(negedge clk);
        send_byte(8'h11, w1);
        send_byte(8'h22, w2);
        send_byte(8'h33, w3);
        dv1 = 1'b0;
        checks++;
        if ({w1, w2, w3} !== {32'd0, 32'd1, 32'd9}) begin
            fails++;
            $display("FAIL bp_ready_waits: %0d,%0d,%0d clks required 0,1,9", w1, w2, w3);
        end
        wait_rx(3);
        repeat (15) @(negedge clk);
        checks++;
        if (got_q.size() !== 3) begin
            fails++;
            $display("FAIL bp_count: %0d bytes required 3", got_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            got  = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            checks++;
            if (got !== expb) begin
                fails++;
                $display("FAIL bp_byte%0d: got %h required %h", i, got, expb);
            end
        end
    endtask

    task automatic test_slow_baud;
        logic [9:0] pat;
        logic [2:0] expv;
        pat = {1'b0, 8'h81, 1'b1};
        checks++;
        if (rdy4 !== 1'b1) begin
            fails++;
            $display("FAIL slow_ready: d_ready=%b required 1", rdy4);
        end
        d4 = 8'h81; dv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv4 = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            expv = {pat[9-(j/4)], 1'b1, (j == 39)};
            checks++;
            if ({tx4, busy4, fd4} !== expv) begin
                fails++;
                $display("FAIL slow_clk%0d: tx,busy,frame_done=%b required %b", j + 1, {tx4, busy4, fd4}, expv);
            end
        end
        @(negedge clk);
        checks++;
        if ({tx4, busy4, fd4} !== 3'b100) begin
            fails++;
            $display("FAIL slow_idle_after: tx,busy,frame_done=%b required 100", {tx4, busy4, fd4});
        end
    endtask

    task automatic test_reset_mid_frame;
        int w, bad = 0;
        logic [7:0] got, expb;
        send_byte(8'hC3, w);
        send_byte(8'h3C, w);
        dv1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy1, rdy1} !== 2'b10) begin
            fails++;
            $display("FAIL midrst_pre: busy,d_ready=%b required 10", {busy1, rdy1});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx1, busy1, rdy1} !== 3'b101) begin
            fails++;
            $display("FAIL midrst_async: tx,busy,d_ready=%b required 101", {tx1, busy1, rdy1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        got_q.delete();
        repeat (30) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || got_q.size() !== 0) begin
            fails++;
            $display("FAIL midrst_residual: %0d active clks, %0d bytes, required 0,0", bad, got_q.size());
        end
        send_byte(8'h5A, w);
        dv1 = 1'b0;
        wait_rx(1);
        got  = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (got !== expb) begin
            fails++;
            $display("FAIL midrst_new_frame: got %h required %h", got, expb);
        end
    endtask

    task automatic test_idle;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({tx1, busy1, fd1, rdy1} !== 4'b1001) begin
                fails++;
                $display("FAIL idle_clk%0d: tx,busy,frame_done,d_ready=%b required 1001", i, {tx1, busy1, fd1, rdy1});
            end
        end
        checks++;
        if (frame_err !== 0) begin
            fails++;
            $display("FAIL final_stop_bits: %0d bad stop bits required 0", frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_loopback_stream();
        test_backpressure();
        test_slow_baud();
        test_reset_mid_frame();
        test_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
